// File: rtl/fpu_rr_scheduler_if.sv
// Requester and shared-FPU signals of the scheduler. The master modport is the outside world
// (requesters plus the FPU they share); the slave modport is the scheduler sitting between them.
interface fpu_rr_scheduler_if #(
    parameter int NUM_M = 4,
    parameter int DW    = 25
);
    logic [NUM_M-1:0]    M_req;
    logic [NUM_M-1:0]    M_op;
    logic [NUM_M*DW-1:0] M_Data1;
    logic [NUM_M*DW-1:0] M_Data2;
    logic [DW-1:0]       M_Dataout;
    logic [NUM_M-1:0]    M_ack;
    logic [NUM_M-1:0]    M_err;
    logic                S_req;
    logic                S_op;
    logic [DW-1:0]       S_Data1;
    logic [DW-1:0]       S_Data2;
    logic [DW-1:0]       S_Datain;
    logic                S_ack;

    modport master (
        output M_req, M_op, M_Data1, M_Data2, S_Datain, S_ack,
        input  M_Dataout, M_ack, M_err, S_req, S_op, S_Data1, S_Data2
    );

    modport slave (
        input  M_req, M_op, M_Data1, M_Data2, S_Datain, S_ack,
        output M_Dataout, M_ack, M_err, S_req, S_op, S_Data1, S_Data2
    );
endinterface

// File: rtl/fpu_rr_scheduler.sv
// Round-robin arbiter sharing one FPU among NUM_M requesters; operands latched at grant.
// Latency: S_req one edge after request is sampled, M_ack/M_err one edge after S_ack/timeout.
// Backpressure: one operation in flight; requesters hold M_req until M_ack/M_err.
module fpu_rr_scheduler #(
    parameter int NUM_M   = 4,
    parameter int DW      = 25,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RSTn,
    fpu_rr_scheduler_if.slave bus,
    output logic              Busy,
    output logic [2:0]        Grant
);
    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] cand;
    logic          win_vld;
    logic [CW-1:0] cnt;
    logic          busy_q;

    function automatic logic [NUM_M-1:0] onehot(input logic [PW-1:0] i);
        logic [NUM_M-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan from the highest offset down so the closest requester to rr_ptr is kept last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k >= NUM_M) ? PW'(int'(rr_ptr) + k - NUM_M)
                                               : PW'(int'(rr_ptr) + k);
            if (bus.M_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign next_ptr = (gidx == PW'(NUM_M - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gidx          <= '0;
            cnt           <= '0;
            busy_q        <= 1'b0;
            bus.S_req     <= 1'b0;
            bus.S_op      <= 1'b0;
            bus.S_Data1   <= '0;
            bus.S_Data2   <= '0;
            bus.M_ack     <= '0;
            bus.M_err     <= '0;
            bus.M_Dataout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gidx        <= win_idx;
                        bus.S_op    <= bus.M_op[win_idx];
                        bus.S_Data1 <= bus.M_Data1[win_idx*DW +: DW];
                        bus.S_Data2 <= bus.M_Data2[win_idx*DW +: DW];
                        bus.S_req   <= 1'b1;
                        cnt         <= '0;
                        busy_q      <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Withdrawal beats a same-cycle S_ack; S_ack beats the timeout.
                    if (!bus.M_req[gidx]) begin
                        bus.S_req <= 1'b0;
                        rr_ptr    <= next_ptr;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.S_ack) begin
                        bus.S_req     <= 1'b0;
                        bus.M_Dataout <= bus.S_Datain;
                        bus.M_ack     <= onehot(gidx);
                        state         <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus.S_req     <= 1'b0;
                        bus.M_Dataout <= '0;
                        bus.M_err     <= onehot(gidx);
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.M_ack <= '0;
                    bus.M_err <= '0;
                    rr_ptr    <= next_ptr;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Busy  = busy_q;
    assign Grant = 3'(gidx);
endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Scoreboard bench: a driver plays requesters and the FPU, a monitor checks every completion pulse.
module tb_fpu_rr_scheduler;
    localparam int NUM_M   = 4;
    localparam int DW      = 25;
    localparam int TIMEOUT = 64;
    localparam int M_ACK   = 0;
    localparam int M_TMO   = 1;
    localparam int M_WDR   = 2;
    localparam int M_RST   = 3;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       Busy;
    logic [2:0] Grant;

    fpu_rr_scheduler_if #(.NUM_M(NUM_M), .DW(DW)) bus ();

    fpu_rr_scheduler #(.NUM_M(NUM_M), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus),
        .Busy (Busy),
        .Grant(Grant)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            idx;
        bit            err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    bit            pend[NUM_M];
    bit            op_a[NUM_M];
    logic [DW-1:0] d1_a[NUM_M];
    logic [DW-1:0] d2_a[NUM_M];
    int            waits[NUM_M];
    int            model_ptr = 0;
    int            max_wait  = 0;
    int            last_grant = 0;
    int            order[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] fpu_result(input bit o, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        if (o) p = a * b;
        else   p = {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
        return p[DW-1:0];
    endfunction

    // Next winner: first pending requester at or after the pointer, wrapping.
    function automatic int model_winner();
        for (int k = 0; k < NUM_M; k++) begin
            if (pend[(model_ptr + k) % NUM_M]) return (model_ptr + k) % NUM_M;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NUM_M; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_m();
        for (int i = 0; i < NUM_M; i++) begin
            bus.M_req[i]              = pend[i];
            bus.M_op[i]               = op_a[i];
            bus.M_Data1[i*DW +: DW]   = d1_a[i];
            bus.M_Data2[i*DW +: DW]   = d2_a[i];
        end
    endtask

    task automatic set_req(input int i, input bit o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        pend[i]  = 1'b1;
        op_a[i]  = o;
        d1_a[i]  = a;
        d2_a[i]  = b;
        waits[i] = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_M; i++) begin
            pend[i]  = 1'b0;
            waits[i] = 0;
        end
        drive_m();
    endtask

    task automatic pulse_reset();
        RSTn = 1'b0;
        clear_all();
        @(posedge CLK); #1;
        RSTn      = 1'b1;
        model_ptr = 0;
    endtask

    task automatic run_txn(input int mode, input int dly);
        int   w;
        int   c;
        int   hi;
        exp_t e;
        drive_m();
        c = 0;
        do begin
            @(posedge CLK); #1;
            c++;
        end while (!bus.S_req && c < 50);
        check("grant_seen", bus.S_req, 1);
        if (!bus.S_req) return;
        w = model_winner();
        if (w < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_without_request: Grant=%0d, required no grant", Grant);
            return;
        end
        last_grant = int'(Grant);
        check("grant_idx", Grant, w);
        check("s_op", bus.S_op, op_a[w]);
        check("s_data1", bus.S_Data1, d1_a[w]);
        check("s_data2", bus.S_Data2, d2_a[w]);
        check("busy_hi", Busy, 1);
        for (int i = 0; i < NUM_M; i++) begin
            if (pend[i] && i != w) begin
                waits[i]++;
                if (waits[i] > max_wait) max_wait = waits[i];
            end
        end
        waits[w] = 0;
        hi = 1;
        case (mode)
            M_ACK: begin
                repeat (dly - 1) begin
                    @(posedge CLK); #1;
                    if (bus.S_req) hi++;
                end
                e.idx  = w;
                e.err  = 1'b0;
                e.data = fpu_result(op_a[w], d1_a[w], d2_a[w]);
                exp_q.push_back(e);
                bus.S_ack    = 1'b1;
                bus.S_Datain = e.data;
                @(posedge CLK); #1;
                bus.S_ack    = 1'b0;
                bus.S_Datain = DW'($urandom);
                check("s_req_hi_cycles", hi, dly);
                check("s_req_drop", bus.S_req, 0);
                pend[w] = 1'b0;
                drive_m();
                model_ptr = (w + 1) % NUM_M;
                @(posedge CLK); #1;
            end
            M_TMO: begin
                e.idx  = w;
                e.err  = 1'b1;
                e.data = '0;
                exp_q.push_back(e);
                c = 0;
                while (bus.S_req && c < TIMEOUT + 10) begin
                    @(posedge CLK); #1;
                    c++;
                    if (bus.S_req) hi++;
                end
                check("tmo_s_req_cycles", hi, TIMEOUT);
                pend[w] = 1'b0;
                drive_m();
                model_ptr = (w + 1) % NUM_M;
                @(posedge CLK); #1;
            end
            M_WDR: begin
                repeat (4) begin
                    @(posedge CLK); #1;
                end
                pend[w] = 1'b0;
                drive_m();
                @(posedge CLK); #1;
                check("wdr_s_req", bus.S_req, 0);
                check("wdr_busy", Busy, 0);
                check("wdr_no_done", {bus.M_ack, bus.M_err}, 0);
                model_ptr = (w + 1) % NUM_M;
            end
            default: begin
                repeat (dly) begin
                    @(posedge CLK); #1;
                end
                RSTn = 1'b0;
                clear_all();
                @(posedge CLK); #1;
                check("rst_s_req", bus.S_req, 0);
                check("rst_s_op", bus.S_op, 0);
                check("rst_s_data1", bus.S_Data1, 0);
                check("rst_s_data2", bus.S_Data2, 0);
                check("rst_m_ack", bus.M_ack, 0);
                check("rst_m_err", bus.M_err, 0);
                check("rst_m_dataout", bus.M_Dataout, 0);
                check("rst_grant", Grant, 0);
                check("rst_busy", Busy, 0);
                RSTn      = 1'b1;
                model_ptr = 0;
                bus.S_ack    = 1'b1;
                bus.S_Datain = DW'($urandom);
                @(posedge CLK); #1;
                bus.S_ack = 1'b0;
                @(posedge CLK); #1;
                check("late_ack_m_ack", bus.M_ack, 0);
                check("late_ack_busy", Busy, 0);
            end
        endcase
    endtask

    task automatic drain();
        while (any_pend()) run_txn(M_ACK, 1);
    endtask

    initial begin : monitor
        exp_t             e;
        logic [NUM_M-1:0] oh;
        forever begin
            @(posedge CLK); #1;
            if ((bus.M_ack | bus.M_err) != '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_completion: M_ack=%b M_err=%b, required none",
                             bus.M_ack, bus.M_err);
                end else begin
                    e        = exp_q.pop_front();
                    oh       = '0;
                    oh[e.idx] = 1'b1;
                    check("m_ack", bus.M_ack, e.err ? '0 : oh);
                    check("m_err", bus.M_err, e.err ? oh : '0);
                    check("m_dataout", bus.M_Dataout, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int r;
        RSTn         = 1'b0;
        bus.S_ack    = 1'b0;
        bus.S_Datain = '0;
        for (int i = 0; i < NUM_M; i++) begin
            pend[i]  = 1'b0;
            op_a[i]  = 1'b0;
            d1_a[i]  = '0;
            d2_a[i]  = '0;
            waits[i] = 0;
        end
        drive_m();
        repeat (3) @(posedge CLK);
        #1;
        check("reset_s_req", bus.S_req, 0);
        check("reset_m_ack", bus.M_ack, 0);
        check("reset_m_err", bus.M_err, 0);
        check("reset_m_dataout", bus.M_Dataout, 0);
        check("reset_grant", Grant, 0);
        check("reset_busy", Busy, 0);
        check("reset_s_data1", bus.S_Data1, 0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        set_req(0, 1'b0, 25'h0AB_CDE, 25'h012_345);
        run_txn(M_ACK, 3);
        check("single_grant", last_grant, 0);
        check("single_dataout", bus.M_Dataout, 25'h0BE_023);

        pulse_reset();
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NUM_M; i++)
                if (!pend[i]) set_req(i, 1'(i & 1), DW'($urandom), DW'($urandom));
            run_txn(M_ACK, 1);
            order[t] = last_grant;
        end
        for (int t = 0; t < 5; t++) check("rr_order", order[t], t % NUM_M);
        drain();

        set_req(2, 1'b1, DW'($urandom), DW'($urandom));
        run_txn(M_TMO, 0);
        check("tmo_grant", last_grant, 2);

        set_req(1, 1'b0, DW'($urandom), DW'($urandom));
        run_txn(M_WDR, 0);
        set_req(0, 1'b0, DW'($urandom), DW'($urandom));
        set_req(3, 1'b1, DW'($urandom), DW'($urandom));
        run_txn(M_ACK, 2);
        check("wdr_next_grant", last_grant, 3);
        drain();

        set_req(int'($urandom_range(0, NUM_M - 1)), 1'b0, DW'($urandom), DW'($urandom));
        run_txn(M_RST, 3);

        set_req(1, 1'b1, DW'($urandom), DW'($urandom));
        run_txn(M_ACK, TIMEOUT);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NUM_M; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
            if (!any_pend()) begin
                n = int'($urandom_range(0, NUM_M - 1));
                set_req(n, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
            end
            r = int'($urandom_range(0, 19));
            if (r == 0)      run_txn(M_TMO, 0);
            else if (r == 1) run_txn(M_ACK, TIMEOUT);
            else if (r == 2) run_txn(M_WDR, 0);
            else             run_txn(M_ACK, int'($urandom_range(1, 6)));
        end
        drain();

        repeat (4) @(posedge CLK);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        check("fairness_max_wait", max_wait <= NUM_M - 1, 1);
        check("idle_at_end", Busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
